// File: rtl/emds_link_arbiter_if.sv
// Handshake bundle between the two User senders, the link arbiter and the shared byte link.
// valid/ready: a byte moves on a rising edge where valid and ready are both high; a sender
// must not make valid depend on ready, and holds data/last stable while valid && !ready.
interface emds_link_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              valid0;
  logic              valid1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              last0;
  logic              last1;
  logic              ready0;
  logic              ready1;
  logic              grant0;
  logic              grant1;
  logic              link_valid;
  logic [DATA_W-1:0] link_data;
  logic              link_src;
  logic              link_last;
  logic              link_ready;
  logic              overflow;
  logic              abort;

  modport slave (
    input  req0, req1, valid0, valid1, data0, data1, last0, last1, link_ready,
    output ready0, ready1, grant0, grant1, link_valid, link_data, link_src, link_last,
           overflow, abort
  );

  modport master (
    output req0, req1, valid0, valid1, data0, data1, last0, last1, link_ready,
    input  ready0, ready1, grant0, grant1, link_valid, link_data, link_src, link_last,
           overflow, abort
  );
endinterface

// File: rtl/emds_link_arbiter.sv
// Message-granular round-robin arbiter sharing one byte link between two User senders.
// Optional stall timeout enabled by defining EMDS_ARB_TIMEOUT_EN.
module emds_link_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 100,
  parameter int TIMEOUT   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  emds_link_arbiter_if.slave bus,
  output logic [1:0]         dbg_state
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DRAIN = 2'd2} state_t;

  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

  if (MAX_BYTES < 1 || MAX_BYTES > 127 || TIMEOUT < 1) begin : g_bad_cfg
    $error("emds_link_arbiter: MAX_BYTES must be 1..127 and TIMEOUT at least 1");
  end

  state_t            state_q, state_d;
  logic              grant0_q, grant0_d;
  logic              grant1_q, grant1_d;
  logic              rr_q, rr_d;
  logic [6:0]        cnt_q, cnt_d;
  logic              link_valid_q, link_valid_d;
  logic [DATA_W-1:0] link_data_q, link_data_d;
  logic              link_src_q, link_src_d;
  logic              link_last_q, link_last_d;
  logic              overflow_q, overflow_d;

  logic              out_free, busy, acc, hit_max, winner;
  logic              g_valid, g_last;
  logic [DATA_W-1:0] g_data;
  logic [6:0]        cnt_inc;

`ifdef EMDS_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               abort_q, abort_d;
`endif

  // The output register can take a new byte when empty or when its byte leaves this cycle.
  assign out_free = !link_valid_q || bus.link_ready;
  assign busy     = (state_q == S_BUSY);
  assign g_valid  = grant1_q ? bus.valid1 : bus.valid0;
  assign g_data   = grant1_q ? bus.data1  : bus.data0;
  assign g_last   = grant1_q ? bus.last1  : bus.last0;
  assign acc      = busy && (grant0_q || grant1_q) && g_valid && out_free;
  assign cnt_inc  = cnt_q + 7'd1;
  assign hit_max  = (cnt_inc == MAX_CNT);
  assign winner   = (bus.req0 && bus.req1) ? rr_q : bus.req1;

  always_comb begin
    state_d      = state_q;
    grant0_d     = grant0_q;
    grant1_d     = grant1_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    link_valid_d = link_valid_q;
    link_data_d  = link_data_q;
    link_src_d   = link_src_q;
    link_last_d  = link_last_q;
    overflow_d   = 1'b0;

    if (acc) begin
      link_valid_d = 1'b1;
      link_data_d  = g_data;
      link_src_d   = grant1_q;
      link_last_d  = g_last || hit_max;
    end else if (bus.link_ready) begin
      link_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant0_d = !winner;
          grant1_d = winner;
          cnt_d    = 7'd0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (acc) begin
          cnt_d = cnt_inc;
          if (g_last || hit_max) begin
            state_d    = S_DRAIN;
            overflow_d = hit_max && !g_last;
          end
        end
      end
      S_DRAIN: begin
        if (link_valid_q && bus.link_ready) begin
          state_d  = S_IDLE;
          grant0_d = 1'b0;
          grant1_d = 1'b0;
          rr_d     = !grant1_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef EMDS_ARB_TIMEOUT_EN
    abort_d = 1'b0;
    stall_d = stall_q;
    if (!busy || acc) begin
      stall_d = '0;
    end else if (!g_valid) begin
      // Revoke the grant: the partial message is abandoned without a last byte.
      if (stall_q == STALL_W'(TIMEOUT - 1)) begin
        abort_d      = 1'b1;
        stall_d      = '0;
        state_d      = S_IDLE;
        grant0_d     = 1'b0;
        grant1_d     = 1'b0;
        rr_d         = !grant1_q;
        link_valid_d = 1'b0;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      grant0_q     <= 1'b0;
      grant1_q     <= 1'b0;
      rr_q         <= 1'b0;
      cnt_q        <= 7'd0;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      link_src_q   <= 1'b0;
      link_last_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant0_q     <= grant0_d;
      grant1_q     <= grant1_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      link_valid_q <= link_valid_d;
      link_data_q  <= link_data_d;
      link_src_q   <= link_src_d;
      link_last_q  <= link_last_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef EMDS_ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end

  assign bus.abort = abort_q;
`else
  assign bus.abort = 1'b0;
`endif

  assign bus.ready0     = busy && grant0_q && out_free;
  assign bus.ready1     = busy && grant1_q && out_free;
  assign bus.grant0     = grant0_q;
  assign bus.grant1     = grant1_q;
  assign bus.link_valid = link_valid_q;
  assign bus.link_data  = link_data_q;
  assign bus.link_src   = link_src_q;
  assign bus.link_last  = link_last_q;
  assign bus.overflow   = overflow_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_emds_link_arbiter.sv
// Bench for emds_link_arbiter: cycle vector table, directed corner sequences and a
// randomized two-user run checked against a per-user message queue model.
module tb_emds_link_arbiter;
  localparam int DATA_W    = 8;
  localparam int MAX_BYTES = 100;
  localparam int TIMEOUT   = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] dbg_state;

  emds_link_arbiter_if #(.DATA_W(DATA_W)) bus ();

  emds_link_arbiter #(.DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-user queues of bytes expected on the link
  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       ovf;
  } item_t;

  item_t      q0[$];
  item_t      q1[$];
  item_t      it;
  int         pos0, pos1;
  int         last_served;
  int         exp_w;
  int         grant_rises = 0;
  int         ovf_pulses  = 0;
  bit         have;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_g0, prev_g1, prev_r0, prev_r1;

  always @(negedge clock) begin
    if (reset_n !== 1'b1) begin
      q0.delete();
      q1.delete();
      pos0 = 0;
      pos1 = 0;
      last_served = 1;
      prev_stall = 1'b0;
      prev_g0 = 1'b0;
      prev_g1 = 1'b0;
      prev_r0 = 1'b0;
      prev_r1 = 1'b0;
    end else begin
      check("grant_onehot", bus.grant0 & bus.grant1, 0);
      check("ready0_ungranted", bus.ready0 & ~bus.grant0, 0);
      check("ready1_ungranted", bus.ready1 & ~bus.grant1, 0);
      check("grant_switch", (prev_g0 & bus.grant1) | (prev_g1 & bus.grant0), 0);
      if (!prev_g0 && !prev_g1 && (bus.grant0 || bus.grant1)) begin
        grant_rises++;
        check("grant_without_req", prev_r0 | prev_r1, 1);
        if (prev_r0 && prev_r1) exp_w = 1 - last_served;
        else exp_w = prev_r1 ? 1 : 0;
        check("arb_winner", bus.grant1, exp_w);
        last_served = bus.grant1 ? 1 : 0;
      end
      if (bus.link_valid) begin
        if (!prev_stall) begin
          have = bus.link_src ? (q1.size() > 0) : (q0.size() > 0);
          check("link_expected", have, 1);
          if (have) begin
            it = bus.link_src ? q1[0] : q0[0];
            check("link_data", bus.link_data, it.data);
            check("link_last", bus.link_last, it.last);
            check("link_overflow", bus.overflow, it.ovf);
          end
        end else begin
          check("link_hold", bus.link_data, prev_data);
          check("overflow_hold", bus.overflow, 0);
        end
        if (bus.link_ready) begin
          if (bus.link_src && q1.size() > 0) void'(q1.pop_front());
          else if (!bus.link_src && q0.size() > 0) void'(q0.pop_front());
        end
      end else begin
        check("overflow_idle", bus.overflow, 0);
      end
      if (bus.abort) begin
        if (prev_g1) begin q1.delete(); pos1 = 0; end
        else begin q0.delete(); pos0 = 0; end
      end
      if (bus.valid0 && bus.ready0) begin
        pos0++;
        it.data = bus.data0;
        it.last = bus.last0 || (pos0 == MAX_BYTES);
        it.ovf  = (pos0 == MAX_BYTES) && !bus.last0;
        q0.push_back(it);
        if (it.last) pos0 = 0;
      end
      if (bus.valid1 && bus.ready1) begin
        pos1++;
        it.data = bus.data1;
        it.last = bus.last1 || (pos1 == MAX_BYTES);
        it.ovf  = (pos1 == MAX_BYTES) && !bus.last1;
        q1.push_back(it);
        if (it.last) pos1 = 0;
      end
      if (bus.overflow) ovf_pulses++;
      prev_stall = bus.link_valid && !bus.link_ready;
      prev_data  = bus.link_data;
      prev_g0    = bus.grant0;
      prev_g1    = bus.grant1;
      prev_r0    = bus.req0;
      prev_r1    = bus.req1;
    end
  end

  // ---------------- driver tasks (called at posedge + 1)
  task automatic drive(input int u, input logic v, input logic [7:0] d, input logic l);
    if (u == 0) begin bus.valid0 = v; bus.data0 = d; bus.last0 = l; end
    else begin bus.valid1 = v; bus.data1 = d; bus.last1 = l; end
  endtask

  task automatic set_req(input int u, input logic r);
    if (u == 0) bus.req0 = r;
    else bus.req1 = r;
  endtask

  task automatic user_msg(input int u, input int len, input int gap_max);
    int         sent  = 0;
    int         pos   = 0;
    int         guard = 0;
    logic [7:0] d     = 8'($urandom);
    logic       v, l, acc;
    set_req(u, 1'b1);
    while (sent < len && guard < 3000) begin
      v = ($urandom_range(0, gap_max) == 0);
      l = (sent == len - 1);
      drive(u, v, d, l);
      @(negedge clock);
      acc = v && ((u == 0) ? bus.ready0 : bus.ready1);
      @(posedge clock); #1;
      guard++;
      if (acc) begin
        sent++;
        pos++;
        d = 8'($urandom);
        if (l) set_req(u, 1'b0);
        else if (pos == MAX_BYTES) begin pos = 0; set_req(u, 1'b1); end
        else set_req(u, 1'b0);
      end
    end
    drive(u, 1'b0, 8'h00, 1'b0);
    set_req(u, 1'b0);
    if (guard >= 3000) check("driver_timeout", 1, 0);
  endtask

  // ---------------- vector table: one row per cycle, user0 only
  typedef struct {
    logic       req0;
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       lr;
    logic       e_lv;
    logic [7:0] e_ld;
    logic       e_ll;
    logic       e_g0;
    logic       e_r0;
  } vec_t;

  typedef struct {
    bit r0;
    bit r1;
    int exp_first;
  } arb_t;

  vec_t vecs[17];
  arb_t arbs[8];
  int   rise_before;
  bit   rand_done;

  initial begin
    #3000000;
    errors++;
    checks++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.valid0 = 0; bus.valid1 = 0;
    bus.data0 = 0; bus.data1 = 0; bus.last0 = 0; bus.last1 = 0; bus.link_ready = 1;

    vecs[0]  = '{1, 1, 8'h41, 0, 1,  0, 8'h00, 0, 0, 0};
    vecs[1]  = '{0, 1, 8'h41, 0, 1,  0, 8'h00, 0, 1, 1};
    vecs[2]  = '{0, 1, 8'h42, 0, 1,  1, 8'h41, 0, 1, 1};
    vecs[3]  = '{0, 1, 8'h43, 1, 1,  1, 8'h42, 0, 1, 1};
    vecs[4]  = '{0, 0, 8'h00, 0, 1,  1, 8'h43, 1, 1, 0};
    vecs[5]  = '{0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0};
    vecs[6]  = '{1, 1, 8'ha0, 0, 1,  0, 8'h00, 0, 0, 0};
    vecs[7]  = '{0, 1, 8'ha0, 0, 1,  0, 8'h00, 0, 1, 1};
    vecs[8]  = '{0, 1, 8'ha1, 0, 0,  1, 8'ha0, 0, 1, 0};
    for (int i = 9; i <= 12; i++) vecs[i] = vecs[8];
    vecs[13] = '{0, 1, 8'ha1, 0, 1,  1, 8'ha0, 0, 1, 1};
    vecs[14] = '{0, 1, 8'ha2, 1, 1,  1, 8'ha1, 0, 1, 1};
    vecs[15] = '{0, 0, 8'h00, 0, 1,  1, 8'ha2, 1, 1, 0};
    vecs[16] = '{0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0};

    arbs[0] = '{1, 1, 0};
    arbs[1] = '{1, 0, 0};
    arbs[2] = '{1, 1, 1};
    arbs[3] = '{0, 1, 1};
    arbs[4] = '{1, 1, 0};
    arbs[5] = '{1, 0, 0};
    arbs[6] = '{1, 0, 0};
    arbs[7] = '{1, 1, 1};

    // reset state
    @(negedge clock);
    check("rst_grant0", bus.grant0, 0);
    check("rst_grant1", bus.grant1, 0);
    check("rst_link_valid", bus.link_valid, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_abort", bus.abort, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // cycle table: 3-byte message, then a message with 5 cycles of backpressure
    for (int i = 0; i < 17; i++) begin
      bus.req0 = vecs[i].req0;
      drive(0, vecs[i].v0, vecs[i].d0, vecs[i].l0);
      bus.link_ready = vecs[i].lr;
      @(negedge clock);
      check($sformatf("vec%0d_link_valid", i), bus.link_valid, vecs[i].e_lv);
      check($sformatf("vec%0d_grant0", i), bus.grant0, vecs[i].e_g0);
      check($sformatf("vec%0d_ready0", i), bus.ready0, vecs[i].e_r0);
      if (vecs[i].e_lv) begin
        check($sformatf("vec%0d_link_data", i), bus.link_data, vecs[i].e_ld);
        check($sformatf("vec%0d_link_last", i), bus.link_last, vecs[i].e_ll);
        check($sformatf("vec%0d_link_src", i), bus.link_src, 0);
      end
      @(posedge clock); #1;
    end

    // 101 bytes from user1 with last only on the 101st: truncation at 100
    bus.link_ready = 1'b1;
    ovf_pulses  = 0;
    rise_before = grant_rises;
    user_msg(1, 101, 0);
    repeat (5) begin @(posedge clock); #1; end
    check("ovf_pulse_count", ovf_pulses, 1);
    check("ovf_regrant_count", grant_rises - rise_before, 2);

    // reset pulsed mid-message
    set_req(0, 1'b1);
    drive(0, 1'b1, 8'h55, 1'b0);
    repeat (4) begin @(posedge clock); #1; end
    @(negedge clock);
    check("pre_reset_grant0", bus.grant0, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_grant0", bus.grant0, 0);
    check("mid_rst_ready0", bus.ready0, 0);
    check("mid_rst_link_valid", bus.link_valid, 0);
    check("mid_rst_link_data", bus.link_data, 0);
    check("mid_rst_link_last", bus.link_last, 0);
    check("mid_rst_state", dbg_state, 0);
    set_req(0, 1'b0);
    drive(0, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;

    // round-robin table; first entry follows the reset, so user0 has priority
    for (int i = 0; i < 8; i++) begin
      arb_t a;
      int   first;
      a = arbs[i];
      first = -1;
      fork
        begin if (a.r0) user_msg(0, 3, 0); end
        begin if (a.r1) user_msg(1, 3, 0); end
        begin
          for (int k = 0; k < 50 && first < 0; k++) begin
            @(negedge clock);
            if (bus.grant0 || bus.grant1) first = bus.grant1 ? 1 : 0;
          end
        end
      join
      check($sformatf("rr%0d_first_grant", i), first, a.exp_first);
      repeat (3) begin @(posedge clock); #1; end
    end

    // randomized two-user traffic with random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int it_n = 0; it_n < 30; it_n++) begin
          int l0, l1, g0, g1, dly;
          bit en0, en1;
          l0  = $urandom_range(1, 6);
          l1  = $urandom_range(1, 6);
          g0  = $urandom_range(0, 2);
          g1  = $urandom_range(0, 2);
          dly = $urandom_range(0, 3);
          en0 = ($urandom_range(0, 3) != 0);
          en1 = ($urandom_range(0, 3) != 0);
          fork
            begin if (en0) user_msg(0, l0, g0); end
            begin
              repeat (dly) begin @(posedge clock); #1; end
              if (en1) user_msg(1, l1, g1);
            end
          join
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clock); #1;
          bus.link_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    bus.link_ready = 1'b1;
    repeat (10) begin @(posedge clock); #1; end
    check("rand_q0_drained", q0.size(), 0);
    check("rand_q1_drained", q1.size(), 0);

`ifdef EMDS_ARB_TIMEOUT_EN
    begin
      int  n;
      bit  found;
      reset_n = 1'b0;
      @(negedge clock);
      #2 reset_n = 1'b1;
      @(posedge clock); #1;
      set_req(0, 1'b1);
      drive(0, 1'b0, 8'h00, 1'b0);
      @(posedge clock); #1;
      set_req(1, 1'b1);
      n = 0;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(negedge clock);
        if (bus.abort) found = 1'b1;
        else if (bus.grant0) n++;
      end
      check("timeout_abort_seen", found, 1);
      check("timeout_stall_cycles", n, TIMEOUT);
      check("timeout_grant0_dropped", bus.grant0, 0);
      @(negedge clock);
      check("timeout_abort_one_cycle", bus.abort, 0);
      check("timeout_req1_granted", bus.grant1, 1);
      @(posedge clock); #1;
      set_req(0, 1'b0);
      user_msg(1, 2, 0);
      repeat (5) begin @(posedge clock); #1; end
    end
`endif

    check("end_q0_empty", q0.size(), 0);
    check("end_q1_empty", q1.size(), 0);
    check("end_state_idle", dbg_state, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
